hilo_divider: RTL and testbench



---
 rtl/hilo_divider_pkg.sv | 23 ++
 rtl/hilo_divider_div_step.sv | 28 ++
 rtl/hilo_divider.sv | 110 +++++++++++
 tb/tb_hilo_divider.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_divider_pkg.sv
// Shared types and constants for the HI/LO iterative divider.
package hilo_divider_pkg;

    // Default operand width of the divider datapath.
    localparam int DIV_WIDTH   = 32;

    // Edges from the accepting edge until out_valid rises.
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Full {hi, lo} result pair; hi carries the remainder, lo the quotient.
    typedef struct packed {
        logic [DIV_WIDTH-1:0] hi;
        logic [DIV_WIDTH-1:0] lo;
    } div_result_t;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring-division step: shift {rem, quot} left by one, then
// subtract the divisor from the partial remainder when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    // The shifted remainder needs one extra bit so the compare never wraps.
    logic [WIDTH:0] remShift;

    // Trial subtraction; the difference always fits in WIDTH bits when taken.
    always_comb begin
        remShift = {rem_i, quot_i[WIDTH-1]};
        if (remShift >= {1'b0, divisor_i}) begin
            rem_o  = remShift[WIDTH-1:0] - divisor_i;
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = remShift[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle unsigned-magnitude divider feeding the Execute-stage HI/LO
// sign fixup. Result is {remainder, quotient}; signed requests divide the
// operand magnitudes and leave the sign correction to downstream logic.
module hilo_divider
    import hilo_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] div_c,
    output logic               busy
);

    div_state_t           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quot_q;
    logic [WIDTH-1:0]     divisor_q;
    logic                 outValid_q;
    logic [2*WIDTH-1:0]   divC_q;

    logic [WIDTH-1:0]     stepRem_d;
    logic [WIDTH-1:0]     stepQuot_d;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;

    // Two's-complement magnitude; the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    assign magA = magnitude(a, is_signed);
    assign magB = magnitude(b, is_signed);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quot_i   (quot_q),
        .divisor_i(divisor_q),
        .rem_o    (stepRem_d),
        .quot_o   (stepQuot_d)
    );

    // A flush in the same cycle blocks acceptance so no request slips past it.
    assign in_ready  = (state_q == IDLE) && !flush;
    assign busy      = (state_q != IDLE);
    assign out_valid = outValid_q;
    assign div_c     = divC_q;

    // Controller and datapath: WIDTH restoring steps, one extra edge to publish.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            outValid_q <= 1'b0;
            divC_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rem_q     <= '0;
                        quot_q    <= magA;
                        divisor_q <= magB;
                        cnt_q     <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(WIDTH)) begin
                        divC_q     <= {rem_q, quot_q};
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        rem_q  <= stepRem_d;
                        quot_q <= stepQuot_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: vector table, hand-written corner
// sequences (backpressure, flush, async reset) and randomized requests
// compared against an arithmetic reference model.
module tb_hilo_divider;
    import hilo_divider_pkg::*;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] div_c;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expC;
    } vec_t;

    vec_t vecs[8];

    hilo_divider #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .div_c    (div_c),
        .busy     (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: magnitudes, then plain division; divide by zero gives all-ones quotient.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] av,
                                           input logic [31:0] bv);
        longint unsigned ma, mb, q, r;
        ma = av;
        mb = bv;
        if (sgn && av[31]) ma = 64'h1_0000_0000 - av;
        if (sgn && bv[31]) mb = 64'h1_0000_0000 - bv;
        if (mb == 0) return {ma[31:0], 32'hFFFF_FFFF};
        q = ma / mb;
        r = ma % mb;
        return {r[31:0], q[31:0]};
    endfunction

    // Single comparison point: every check steps the counters here.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one request, then count edges until out_valid (bounded).
    task automatic applyStimulus(input logic sgn, input logic [31:0] av,
                                 input logic [31:0] bv, output logic [63:0] res,
                                 output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        is_signed = sgn;
        a         = av;
        b         = bv;
        #1;
        checkOutput("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = div_c;
    endtask

    // Consumer takes the result; controller must be idle right after.
    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("valid_drop", out_valid, 0);
        checkOutput("busy_drop", busy, 0);
    endtask

    // Main sequence.
    initial begin
        logic [63:0] res;
        logic [63:0] expC;
        int          lat;
        int          seen;
        logic        sgn;
        logic [31:0] ra;
        logic [31:0] rb;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{"udiv_100_7",     1'b0, 32'd100,       32'd7,         64'h00000002_0000000E};
        vecs[1] = '{"sdiv_m7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         64'h00000001_00000003};
        vecs[2] = '{"sdiv_min_m1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000};
        vecs[3] = '{"udiv_by_zero",   1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF};
        vecs[4] = '{"udiv_big_2",     1'b0, 32'hFFFFFFF9,  32'd2,         64'h00000001_7FFFFFFC};
        vecs[5] = '{"udiv_min_max",   1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000};
        vecs[6] = '{"sdiv_min_zero",  1'b1, 32'h80000000,  32'd0,         64'h80000000_FFFFFFFF};
        vecs[7] = '{"sdiv_m100_m7",   1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'h00000002_0000000E};

        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_div_c", div_c, 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
            checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(DIV_LATENCY));
            checkOutput(vecs[i].name, res, vecs[i].expC);
            releaseResult();
        end

        // Backpressure: result and valid hold while the consumer stalls.
        applyStimulus(1'b0, 32'd1000, 32'd13, res, lat);
        checkOutput("bp_latency", 64'(lat), 64'(DIV_LATENCY));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'd77;
            b        = 32'd5;
            #1;
            checkOutput("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_div_c", div_c, 64'h0000000C_0000004C);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_busy", busy, 0);
        checkOutput("bp_release_ready", in_ready, 1);

        // Flush mid-RUN: abort, block the concurrent request, never publish.
        @(negedge clk);
        in_valid  = 1'b1;
        is_signed = 1'b0;
        a         = 32'd1000;
        b         = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        checkOutput("flush_busy_before", busy, 1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_busy_after", busy, 0);
        checkOutput("flush_out_valid", out_valid, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        checkOutput("flush_stays_idle", 64'(seen), 64'd0);
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'h10, res, lat);
        checkOutput("post_flush_latency", 64'(lat), 64'(DIV_LATENCY));
        checkOutput("post_flush_div_c", res, 64'h0000000F_0FFFFFFF);
        releaseResult();

        // Flush while DONE with the consumer stalled drops the result.
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, res, lat);
        checkOutput("done_flush_div_c", res, 64'h00000002_0000000E);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("done_flush_valid", out_valid, 0);
        checkOutput("done_flush_busy", busy, 0);
        checkOutput("done_flush_hold", div_c, 64'h00000002_0000000E);

        // Asynchronous reset between edges while running.
        @(negedge clk);
        in_valid  = 1'b1;
        is_signed = 1'b0;
        a         = 32'h12345678;
        b         = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        checkOutput("arst_div_c", div_c, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 32'd9, 32'd3, res, lat);
        checkOutput("arst_after_latency", 64'(lat), 64'(DIV_LATENCY));
        checkOutput("arst_after_div_c", res, 64'h00000000_00000003);
        releaseResult();

        // Randomized requests against the reference model.
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'd0;
                default: rb = ra >> $urandom_range(0, 8);
            endcase
            expC = refDiv(sgn, ra, rb);
            applyStimulus(sgn, ra, rb, res, lat);
            checkOutput("rand_latency", 64'(lat), 64'(DIV_LATENCY));
            checkOutput("rand_div_c", res, expC);
            releaseResult();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
